pulse_gen_multi: RTL and testbench

Parametrised multi-channel pulse generator driven from logic-analyzer (LA) configuration pins and sitting inside the user project area. It generalises the single-channel pulse generator to NUM_CH independent channels. Each channel has its own programmable period and high width, with optional finite-burst mode. Configuration is written through a small strobe-qualified register port; period and width changes made while a channel runs take effect glitch-free at the next period boundary.

---
 rtl/pulse_gen_multi.sv | 189 ++++++++++++++++++
 tb/tb_pulse_gen_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_gen_multi.sv
// Purpose : NUM_CH independent programmable pulse generators with an optional finite-burst mode.
// Latency : a config write takes effect at the write edge; outputs change in the cycle after it.
// Backpress: none; each rising edge of cfg_we_i commits exactly one write, and a held strobe writes once.
//
// Ports:
//   wb_clk_i    - sole clock, rising edge
//   wb_rst_ni   - asynchronous active-low reset
//   cfg_we_i    - write strobe (rising-edge qualified)
//   cfg_addr_i  - {channel, reg}; reg 0=PERIOD 1=WIDTH 2=BURST 3=CTRL{mode,en}
//   cfg_data_i  - write data
//   pulse_o     - per-channel pulse output
//   busy_o      - per-channel RUN indication
//   done_o      - per-channel sticky burst-complete flag
//
// Build option: define PULSE_GEN_BURST_EN to enable BURST, the mode bit and done_o.
// Without it, channels run continuously and done_o is tied low.

module pulse_gen_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_ni,
    input  logic                        cfg_we_i,
    input  logic [$clog2(NUM_CH)+2-1:0] cfg_addr_i,
    input  logic [CNT_W-1:0]            cfg_data_i,
    output logic [NUM_CH-1:0]           pulse_o,
    output logic [NUM_CH-1:0]           busy_o,
    output logic [NUM_CH-1:0]           done_o
);

    localparam int AW   = $clog2(NUM_CH) + 2;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] REG_PERIOD = 2'd0;
    localparam logic [1:0] REG_WIDTH  = 2'd1;
    localparam logic [1:0] REG_BURST  = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Rising-edge detect on the write strobe: a held strobe commits only once.
    logic we_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q <= 1'b0;
        end else begin
            we_q <= cfg_we_i;
        end
    end

    logic            wr_stb;
    logic [1:0]      wr_reg;
    logic [CH_W-1:0] wr_ch;

    assign wr_stb = cfg_we_i & ~we_q;
    assign wr_reg = cfg_addr_i[1:0];

    generate
        if (NUM_CH > 1) begin : g_ch_dec
            assign wr_ch = cfg_addr_i[AW-1:2];
        end else begin : g_ch_one
            assign wr_ch = '0;
        end
    endgenerate

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            // Out-of-range channel numbers match no channel, so they fall away here.
            logic       sel;
            logic       ctrl_wr;
            logic       start;
            logic       stop;
            logic       tick;
            logic       wrap;
            logic       last;
            state_t     state;

            logic [CNT_W-1:0] period_stg;
            logic [CNT_W-1:0] width_stg;
            logic [CNT_W-1:0] period_act;
            logic [CNT_W-1:0] width_act;
            logic [CNT_W-1:0] cnt;

            assign sel     = wr_stb && (wr_ch == CH_W'(c));
            assign ctrl_wr = sel && (wr_reg == REG_CTRL);
            // A start needs a non-zero staged period; otherwise the write is a no-op.
            assign start   = ctrl_wr && cfg_data_i[0] && (period_stg != '0);
            assign stop    = ctrl_wr && !cfg_data_i[0];
            // A start or stop on this edge overrides normal counting.
            assign tick    = (state == ST_RUN) && !start && !stop;
            assign wrap    = tick && (cnt == (period_act - CNT_W'(1)));

            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    state      <= ST_IDLE;
                    period_stg <= '0;
                    width_stg  <= '0;
                    period_act <= '0;
                    width_act  <= '0;
                    cnt        <= '0;
                end else begin
                    if (sel && (wr_reg == REG_PERIOD)) begin
                        period_stg <= cfg_data_i;
                    end
                    if (sel && (wr_reg == REG_WIDTH)) begin
                        width_stg <= cfg_data_i;
                    end

                    if (start) begin
                        state      <= ST_RUN;
                        period_act <= period_stg;
                        width_act  <= width_stg;
                        cnt        <= '0;
                    end else if (stop) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (wrap) begin
                        cnt <= '0;
                        if (last) begin
                            state <= ST_IDLE;
                        end else begin
                            // Period boundary: adopt staged values so changes never cut a pulse short.
                            width_act <= width_stg;
                            if (period_stg != '0) begin
                                period_act <= period_stg;
                            end
                        end
                    end else if (tick) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end

`ifdef PULSE_GEN_BURST_EN
            logic             mode;
            logic             done;
            logic [CNT_W-1:0] burst;
            logic [CNT_W-1:0] pcnt;
            logic [CNT_W-1:0] burst_last;

            // BURST=0 behaves like a single-pulse burst.
            assign burst_last = (burst == '0) ? '0 : (burst - CNT_W'(1));
            assign last       = mode && (pcnt == burst_last);

            always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
                if (!wb_rst_ni) begin
                    mode  <= 1'b0;
                    done  <= 1'b0;
                    burst <= '0;
                    pcnt  <= '0;
                end else begin
                    if (sel && (wr_reg == REG_BURST)) begin
                        burst <= cfg_data_i;
                    end
                    if (ctrl_wr) begin
                        mode <= cfg_data_i[1];
                    end

                    if (start) begin
                        pcnt <= '0;
                        done <= 1'b0;
                    end else if (wrap) begin
                        if (last) begin
                            done <= 1'b1;
                        end else begin
                            pcnt <= pcnt + CNT_W'(1);
                        end
                    end
                end
            end

            assign done_o[c] = done;
`else
            assign last      = 1'b0;
            assign done_o[c] = 1'b0;
`endif

            // Decoded from registered state only, so the output is glitch-free;
            // reset clears state asynchronously, forcing the pulse low at once.
            assign busy_o[c]  = (state == ST_RUN);
            assign pulse_o[c] = (state == ST_RUN) && (cnt < width_act);
        end
    endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
module tb_pulse_gen_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int AW     = $clog2(NUM_CH) + 2;

`ifdef PULSE_GEN_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              we    = 1'b0;
    logic [AW-1:0]     addr  = '0;
    logic [CNT_W-1:0]  data  = '0;
    logic [NUM_CH-1:0] pulse;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] done;

    always #5 clk = ~clk;

    pulse_gen_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .cfg_we_i   (we),
        .cfg_addr_i (addr),
        .cfg_data_i (data),
        .pulse_o    (pulse),
        .busy_o     (busy),
        .done_o     (done)
    );

    typedef struct {
        int   ch;
        logic p;
        logic b;
        logic d;
        int   tag;
        int   cyc;
    } exp_t;

    typedef struct {
        int ch;
        int p;
        int w;
        int b;
        bit m;
        int n;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;
    logic last_done [NUM_CH];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    // One clock; the sample point is the falling edge. Pops one scoreboard entry if any.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if ({pulse[e.ch], busy[e.ch], done[e.ch]} !== {e.p, e.b, e.d}) begin
                fails++;
                $display("FAIL sb tag=%0d cyc=%0d ch=%0d got p/b/d=%b%b%b exp=%b%b%b",
                         e.tag, e.cyc, e.ch, pulse[e.ch], busy[e.ch], done[e.ch],
                         e.p, e.b, e.d);
            end
        end
    endtask

    // Strobe high for one cycle, then low for one so the next write sees a fresh edge.
    task automatic wr(input int ch, input int r, input int d);
        addr = AW'((ch << 2) | r);
        data = CNT_W'(d);
        we   = 1'b1;
        tick();
        we   = 1'b0;
        tick();
    endtask

    task automatic push(input int ch, input logic p, input logic b, input logic d,
                        input int tag, input int cyc);
        exp_t e;
        e.ch = ch; e.p = p; e.b = b; e.d = d; e.tag = tag; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Reference model: sample k is the k-th cycle after the start edge.
    task automatic push_run(input int ch, input int p, input int w, input int b,
                            input bit m, input int n, input int tag);
        int total;
        total = (BURST_ON && m) ? p * ((b == 0) ? 1 : b) : -1;
        for (int k = 0; k < n; k++) begin
            if (total >= 0 && k >= total)
                push(ch, 1'b0, 1'b0, 1'b1, tag, k);
            else
                push(ch, ((k % p) < w), 1'b1, 1'b0, tag, k);
        end
        last_done[ch] = (total >= 0) && ((n - 1) >= total);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("drain_bound", 32'(sb.size()), 32'd0);
    endtask

    task automatic stop_ch(input int ch, input int tag);
        push(ch, 1'b0, 1'b0, last_done[ch], tag, 100);
        push(ch, 1'b0, 1'b0, last_done[ch], tag, 101);
        wr(ch, 3, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{ch:0, p:10, w:3,  b:0, m:1'b0, n:25};
        vecs[1] = '{ch:1, p:5,  w:2,  b:4, m:1'b1, n:26};
        vecs[2] = '{ch:2, p:4,  w:0,  b:0, m:1'b0, n:10};
        vecs[3] = '{ch:3, p:8,  w:12, b:0, m:1'b0, n:18};
        vecs[4] = '{ch:2, p:3,  w:1,  b:0, m:1'b1, n:7};
        vecs[5] = '{ch:0, p:1,  w:1,  b:0, m:1'b0, n:5};
        vecs[6] = '{ch:3, p:6,  w:6,  b:2, m:1'b1, n:16};
        for (int i = 0; i < NUM_CH; i++) last_done[i] = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_pulse", 32'(pulse), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Table-driven runs
        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].ch, 0, vecs[i].p);
            wr(vecs[i].ch, 1, vecs[i].w);
            wr(vecs[i].ch, 2, vecs[i].b);
            push_run(vecs[i].ch, vecs[i].p, vecs[i].w, vecs[i].b, vecs[i].m, vecs[i].n, i);
            wr(vecs[i].ch, 3, (int'(vecs[i].m) << 1) | 1);
            drain();
            stop_ch(vecs[i].ch, 50 + i);
        end

        // Mid-period width change: current period keeps 3, next gets 6
        wr(0, 0, 10);
        wr(0, 1, 3);
        for (int k = 0; k < 20; k++)
            push(0, (k < 10) ? (k < 3) : ((k - 10) < 6), 1'b1, 1'b0, 20, k);
        last_done[0] = 1'b0;
        wr(0, 3, 1);
        tick();
        tick();
        wr(0, 1, 6);
        drain();
        stop_ch(0, 21);

        // Held strobe writes once: PERIOD must be 4, not 7
        wr(1, 1, 1);
        addr = AW'((1 << 2) | 0);
        data = CNT_W'(4);
        we   = 1'b1;
        tick();
        data = CNT_W'(7);
        repeat (4) tick();
        we = 1'b0;
        tick();
        push_run(1, 4, 1, 0, 1'b0, 12, 30);
        wr(1, 3, 1);
        drain();
        stop_ch(1, 31);

        // Start with PERIOD=0 leaves the channel idle
        wr(2, 0, 0);
        push(2, 1'b0, 1'b0, last_done[2], 40, 0);
        push(2, 1'b0, 1'b0, last_done[2], 40, 1);
        wr(2, 3, 1);
        tick();
        chk("p0_busy", 32'(busy[2]), 32'd0);

        // All channels running, then asynchronous reset mid-run
        for (int c = 0; c < NUM_CH; c++) begin
            wr(c, 0, 5);
            wr(c, 1, 5);
            wr(c, 3, 1);
        end
        tick();
        chk("all_pulse", 32'(pulse), 32'hF);
        chk("all_busy",  32'(busy),  32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pulse", 32'(pulse), 32'd0);
        chk("arst_busy",  32'(busy),  32'd0);
        chk("arst_done",  32'(done),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        chk("rel_pulse", 32'(pulse), 32'd0);
        chk("rel_busy",  32'(busy),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
